// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read side: 2-flop write-pointer sync, read pointer, registered FWFT output stage.
// First word appears 3 rd_clk edges after wr_ptr_gray settles; rd_data holds while rd_valid && !rd_ready.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  i_rd_clk,
    input  logic                  i_rd_rst,
    input  logic [ADDR_WIDTH:0]   i_wr_ptr_gray,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
    output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic                  o_fifo_empty,
    output logic                  o_fifo_aempty,
    output logic [ADDR_WIDTH:0]   o_rd_level
);

    localparam logic [ADDR_WIDTH:0] LP_AEMPTY_THRESH = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH:0]   r_wq1;
    logic [ADDR_WIDTH:0]   r_wq2;
    logic [ADDR_WIDTH:0]   r_rbin;
    logic [ADDR_WIDTH:0]   r_rgray;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;

    logic [ADDR_WIDTH:0]   w_wbin_s;
    logic [ADDR_WIDTH:0]   w_rbin_nxt;
    logic [ADDR_WIDTH:0]   w_rgray_nxt;
    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_mem_empty;
    logic                  w_pop;

    // Synchronizer pair: nothing but r_wq2 may observe r_wq1.
    always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
        if (i_rd_rst) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= i_wr_ptr_gray;
            r_wq2 <= r_wq1;
        end
    end

    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i <= ADDR_WIDTH; i++) begin
            w_wbin_s[i] = ^(r_wq2 >> i);
        end
    end

    assign w_rbin_nxt  = r_rbin + (ADDR_WIDTH+1)'(1);
    assign w_rgray_nxt = w_rbin_nxt ^ (w_rbin_nxt >> 1);
    assign w_mem_empty = (r_rgray == r_wq2);
    assign w_level     = w_wbin_s - r_rbin;
    assign w_pop       = !w_mem_empty && (!r_rd_valid || i_rd_ready);

    always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
        if (i_rd_rst) begin
            r_rbin     <= '0;
            r_rgray    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_pop) begin
            r_rd_data  <= i_mem_rd_data;
            r_rd_valid <= 1'b1;
            r_rbin     <= w_rbin_nxt;
            r_rgray    <= w_rgray_nxt;
        end else if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign o_rd_addr     = r_rbin[ADDR_WIDTH-1:0];
    assign o_rd_ptr_gray = r_rgray;
    assign o_rd_data     = r_rd_data;
    assign o_rd_valid    = r_rd_valid;
    assign o_fifo_empty  = w_mem_empty;
    assign o_rd_level    = w_level;
    assign o_fifo_aempty = (w_level <= LP_AEMPTY_THRESH);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural write side + memory, scoreboard queue checked by a monitor.
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] wr_ptr_gray;
    logic [3:0] rd_addr;
    logic [7:0] mem_rd_data;
    logic [4:0] rd_ptr_gray;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       fifo_empty;
    logic       fifo_aempty;
    logic [4:0] rd_level;

    logic [7:0] mem [16];
    logic [4:0] wbin;
    logic [7:0] exp_q [$];
    int         n_checks;
    int         n_fail;

    fifo_rd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AEMPTY_THRESH(2)) dut (
        .i_rd_clk      (clk),
        .i_rd_rst      (rst),
        .i_wr_ptr_gray (wr_ptr_gray),
        .o_rd_addr     (rd_addr),
        .i_mem_rd_data (mem_rd_data),
        .o_rd_ptr_gray (rd_ptr_gray),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .i_rd_ready    (rd_ready),
        .o_fifo_empty  (fifo_empty),
        .o_fifo_aempty (fifo_aempty),
        .o_rd_level    (rd_level)
    );

    assign wr_ptr_gray = wbin ^ (wbin >> 1);
    assign mem_rd_data = mem[rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        wbin = wbin + 5'd1;
        exp_q.push_back(d);
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data != e) begin
                    n_fail++;
                    $display("FAIL sb_data: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        rd_ready = 1'b0;
        wbin     = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset asserted mid-cycle takes effect without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_valid",  rd_valid,    0);
        chk("rst_data",   rd_data,     0);
        chk("rst_empty",  fifo_empty,  1);
        chk("rst_aempty", fifo_aempty, 1);
        chk("rst_level",  rd_level,    0);
        chk("rst_ptr",    rd_ptr_gray, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // First-word latency.
        wr(8'hA5);
        tick();
        chk("lat_e1_empty", fifo_empty, 1);
        tick();
        chk("lat_e2_empty", fifo_empty, 0);
        chk("lat_e2_level", rd_level,   1);
        chk("lat_e2_valid", rd_valid,   0);
        tick();
        chk("lat_e3_valid", rd_valid,    1);
        chk("lat_e3_data",  rd_data,     8'hA5);
        chk("lat_e3_ptr",   rd_ptr_gray, 5'b00001);

        // Backpressure with three words behind the output register.
        wr(8'h11); tick();
        wr(8'h22); tick();
        wr(8'h33); tick();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_data",  rd_data,  8'hA5);
            chk("bp_addr",  rd_addr,  1);
            chk("bp_level", rd_level, 3);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_no_bubble", rd_valid, 1);
        end
        tick();
        chk("bp_done_valid", rd_valid, 0);
        chk("bp_done_empty", fifo_empty, 1);

        // Streaming traffic moves both pointers to 20.
        for (int i = 0; i < 16; i++) begin
            wr(8'h80 + 8'(i));
            tick();
        end
        wait_drain("stream_drained");
        chk("stream_level", rd_level, 0);

        // Fill: one word sits in the output register, 16 in memory.
        rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr(8'h40 + 8'(i));
            tick();
        end
        tick(); tick(); tick();
        chk("full_level",  rd_level,    16);
        chk("full_aempty", fifo_aempty, 0);
        chk("full_empty",  fifo_empty,  0);
        chk("full_data",   rd_data,     8'h40);
        chk("full_ptr",    rd_ptr_gray, gray(5'd21));

        // Drain across the pointer wrap; level falls by one per edge.
        rd_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("drain_level",  rd_level,    16 - k);
            chk("drain_aempty", fifo_aempty, ((16 - k) <= 2) ? 1 : 0);
        end
        tick();
        chk("drain_valid_off", rd_valid, 0);
        for (int i = 0; i < 3; i++) begin
            wr(8'hE0 + 8'(i));
            tick();
        end
        wait_drain("wrap_drained");
        chk("wrap_ptr", rd_ptr_gray, gray(5'd8));

        // Empty reads: ready toggling must not move anything.
        for (int i = 0; i < 10; i++) begin
            rd_ready = ~rd_ready;
            tick();
            chk("empty_valid", rd_valid,    0);
            chk("empty_ptr",   rd_ptr_gray, gray(wbin));
        end

        // Last word leaves on the same edge a new pointer lands in wq2.
        rd_ready = 1'b0;
        wr(8'hC3);
        tick(); tick(); tick();
        chk("sim_hold_valid", rd_valid, 1);
        wr(8'h3C);
        tick();
        rd_ready = 1'b1;
        tick();
        chk("sim_bubble_valid", rd_valid,   0);
        chk("sim_bubble_empty", fifo_empty, 0);
        chk("sim_bubble_level", rd_level,   1);
        tick();
        chk("sim_new_valid", rd_valid, 1);
        chk("sim_new_data",  rd_data,  8'h3C);
        tick();
        rd_ready = 1'b0;
        chk("sim_drained", exp_q.size(), 0);

        // Reset mid-operation discards the held word.
        wr(8'h5A);
        tick(); tick(); tick();
        chk("mid_pre_valid", rd_valid, 1);
        @(negedge clk);
        #2;
        rst  = 1'b1;
        wbin = '0;
        #1;
        exp_q.delete();
        chk("mid_valid", rd_valid,    0);
        chk("mid_data",  rd_data,     0);
        chk("mid_empty", fifo_empty,  1);
        chk("mid_level", rd_level,    0);
        chk("mid_ptr",   rd_ptr_gray, 0);
        chk("mid_addr",  rd_addr,     0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", rd_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, clocked entirely in the read domain. It brings the write pointer across the clock boundary, keeps the read pointer, and drives the read address into the FIFO memory. It returns data to the consumer through a registered first-word-fall-through valid/ready stage. It also exports the Gray-coded read pointer so the write side can compute its full flag.

## Interface
- DATA_WIDTH, 8, width of one FIFO word
- ADDR_WIDTH, 4, memory address width; DEPTH = 2^ADDR_WIDTH
- AEMPTY_THRESH, 2, fifo_aempty asserts when rd_level <= this value

- rd_clk  in  1  read-domain clock; the only clock in this block
- rd_rst  in  1  reset, asynchronous, active-high
- wr_ptr_gray  in  ADDR_WIDTH+1  Gray-coded write pointer from the write domain; asynchronous to rd_clk
- rd_addr  out  ADDR_WIDTH  read address into the FIFO memory
- mem_rd_data  in  DATA_WIDTH  combinational memory output at rd_addr
- rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray-coded read pointer, sent to the write domain
- rd_data  out  DATA_WIDTH  output word, registered
- rd_valid  out  1  rd_data holds a valid word
- rd_ready  in  1  consumer accepts rd_data in this cycle
- fifo_empty  out  1  memory holds no unread words (the output register is not counted)
- fifo_aempty  out  1  rd_level <= AEMPTY_THRESH
- rd_level  out  ADDR_WIDTH+1  words in memory as seen from the read domain (0..DEPTH)

## Operation
- **Synchronizer:** two flops, wq1 then wq2, clocked by rd_clk, capture wr_ptr_gray. No other logic touches wq1.
- **Pointer conversion:** wbin_s = Gray-to-binary(wq2).
- **Read pointer:** the binary pointer rbin and its Gray code rgray are both ADDR_WIDTH+1 bits and are registered together. rgray = rbin ^ (rbin >> 1). rd_ptr_gray = rgray. rd_addr = rbin[ADDR_WIDTH-1:0].
- **Memory empty:** mem_empty = (rgray == wq2). This term is combinational from registers only. fifo_empty = mem_empty.
- **Level:** rd_level = (wbin_s - rbin) modulo 2^(ADDR_WIDTH+1). fifo_aempty = (rd_level <= AEMPTY_THRESH).
- **Pop condition:** pop = !mem_empty && (!rd_valid || rd_ready).
- **On pop:**
  - rd_data <= mem_rd_data
  - rd_valid <= 1
  - rbin <= rbin + 1 (rgray follows in the same edge)
- **No pop, rd_ready = 1:** rd_valid <= 0. rd_data holds its value.
- **No pop, rd_ready = 0:** all state holds. rd_data stays stable while rd_valid && !rd_ready.
- **Handshake:** a transfer happens on a rd_clk edge where rd_valid && rd_ready.
- **Throughput:** one word per cycle while memory is non-empty and rd_ready stays high. rd_valid stays 1 across back-to-back transfers.
- **rd_ready with rd_valid = 0:** ignored; no state change beyond the pop rule.
- **Wrap-around:** pointers wrap modulo 2^(ADDR_WIDTH+1). The extra MSB tells full from empty, so a full memory gives rd_level = DEPTH.
- **Pointer legality:** wr_ptr_gray must change by at most one Gray step per write-clock edge. That is the write side's responsibility and is not checked here.

## Timing
- **Reset (asynchronous, takes effect immediately):**
  - rbin = 0, rgray = 0, wq1 = wq2 = 0
  - rd_data = 0, rd_valid = 0
  - Resulting outputs: rd_addr = 0, rd_ptr_gray = 0, fifo_empty = 1, rd_level = 0, fifo_aempty = 1
  - Deassertion is used synchronously to rd_clk by the integrator.
- **Reset mid-operation:** all state clears at once and any word in the output register is lost. The write side must be reset in the same event.
- **Write-to-read latency**, counted from wr_ptr_gray becoming stable before a rd_clk edge:
  - edge 1: wq1 updates
  - edge 2: wq2 updates; fifo_empty drops and rd_level rises in that cycle
  - edge 3: rd_valid = 1 and rd_data = first word
- **Read pointer export:** rd_ptr_gray changes on the same edge as the pop. It is glitch-free because it comes straight from a register.
- **Freeing a slot:** after a transfer, one memory slot is freed one edge later as seen by rd_ptr_gray.
- **Level update:** rd_level and the flags update in the cycle after any pointer change.

## Test plan
- **Reset values:** assert rd_rst mid-cycle -> immediately rd_valid = 0, rd_data = 0, fifo_empty = 1, fifo_aempty = 1, rd_level = 0, rd_ptr_gray = 0.
- **First-word latency:** drive wr_ptr_gray 0 -> 1 (Gray 00001) with memory word 0xA5 at address 0 and rd_ready = 0 -> fifo_empty falls after 2 edges; on edge 3 rd_valid = 1, rd_data = 0xA5, rd_ptr_gray = 00001.
- **Backpressure:** with rd_valid = 1 and 3 words in memory, hold rd_ready = 0 for 5 cycles -> rd_data stable, rd_addr constant, rd_level = 3. Release rd_ready -> one word transfers per cycle, with no bubble until memory is empty.
- **Full and wrap:** fill DEPTH = 16 words -> rd_level = 16 and fifo_aempty = 0. Drain 20 words across a pointer wrap (rbin 31 -> 0) -> data arrives in order, and fifo_aempty asserts when rd_level <= 2.
- **Empty reads:** with fifo_empty = 1 and rd_valid = 0, toggle rd_ready for 10 cycles -> rbin unchanged and rd_valid stays 0.
- **Simultaneous events:** on the same edge, rd_ready transfers the last output word and a new write pointer arrives in wq2 -> that cycle's pop is blocked (mem_empty still true). rd_valid drops for one cycle, then reasserts on the next edge with the new word.
